// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper_if
// Brief    : Verdict/start inputs and game-status outputs of score_keeper.
//            The master drives Result/Start; the slave (score_keeper) drives
//            the registered status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface score_keeper_if;
  logic [1:0] Result;
  logic       Start;
  logic [7:0] Score;
  logic [2:0] Lives;
  logic       Playing;
  logic       Win;
  logic       Game_over;
  logic       Event;

  modport master (
    output Result, Start,
    input  Score, Lives, Playing, Win, Game_over, Event
  );

  modport slave (
    input  Result, Start,
    output Score, Lives, Playing, Win, Game_over, Event
  );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Round-based game scorer. Counts edge-detected verdicts while a
//            round is in progress; the round ends in WIN when the score hits
//            TARGET_SCORE or in LOSE when the lives run out. All outputs are
//            registered, so every effect appears one cycle after its cause.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter int TARGET_SCORE = 10,  // 1..255
  parameter int START_LIVES  = 3    // 1..7
) (
  input  logic          Clock,
  input  logic          Reset,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  localparam logic [7:0] c_target      = 8'(TARGET_SCORE);
  localparam logic [2:0] c_start_lives = 3'(START_LIVES);
  localparam logic [1:0] c_correct     = 2'b01;
  localparam logic [1:0] c_wrong       = 2'b10;

  state_t     r_state;
  state_t     w_state;
  logic [1:0] r_prev;
  logic [7:0] r_score;
  logic [7:0] w_score;
  logic [2:0] r_lives;
  logic [2:0] w_lives;
  logic       w_event;
  logic       r_event;
  logic       r_playing;
  logic       r_win;
  logic       r_lose;
  logic       w_new_verdict;

  // A verdict counts only on the cycle it appears or changes, so a held
  // Result is seen once; 01<->10 flips count as fresh verdicts.
  assign w_new_verdict = ((bus.Result == c_correct) || (bus.Result == c_wrong)) &&
                         (bus.Result != r_prev);

  // Verdict history: tracks Result every cycle regardless of state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_prev <= 2'b00;
    end else begin
      r_prev <= bus.Result;
    end
  end

  // State, counters and registered status flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_score   <= 8'd0;
      r_lives   <= 3'd0;
      r_event   <= 1'b0;
      r_playing <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_score   <= w_score;
      r_lives   <= w_lives;
      r_event   <= w_event;
      r_playing <= (w_state == PLAY);
      r_win     <= (w_state == WIN);
      r_lose    <= (w_state == LOSE);
    end
  end

  // Next-state and counter update; outside PLAY only Start has any effect,
  // and a Start reload there swallows any coincident verdict.
  always_comb begin
    w_state = r_state;
    w_score = r_score;
    w_lives = r_lives;
    w_event = 1'b0;
    case (r_state)
      IDLE, WIN, LOSE: begin
        if (bus.Start) begin
          w_state = PLAY;
          w_score = 8'd0;
          w_lives = c_start_lives;
        end
      end
      PLAY: begin
        if (w_new_verdict && (bus.Result == c_correct)) begin
          w_score = r_score + 8'd1;
          w_event = 1'b1;
          if ((r_score + 8'd1) == c_target) begin
            w_state = WIN;
          end
        end else if (w_new_verdict && (bus.Result == c_wrong)) begin
          // Lives is at least 1 in PLAY, so this cannot wrap.
          w_lives = r_lives - 3'd1;
          w_event = 1'b1;
          if (r_lives == 3'd1) begin
            w_state = LOSE;
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus.Score     = r_score;
  assign bus.Lives     = r_lives;
  assign bus.Playing   = r_playing;
  assign bus.Win       = r_win;
  assign bus.Game_over = r_lose;
  assign bus.Event     = r_event;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Directed bench for score_keeper. Each step drives inputs, queues
//            the outputs expected after the next rising edge, and compares
//            them once the edge has passed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

  logic Clock;
  logic Reset;
  score_keeper_if bus ();

  score_keeper #(
    .TARGET_SCORE (10),
    .START_LIVES  (3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] score;
    logic [2:0] lives;
    logic       playing;
    logic       win;
    logic       lose;
    logic       evt;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input logic [1:0] res, input logic st, input logic rs,
                      input logic [7:0] sc, input logic [2:0] lv,
                      input logic pl, input logic wn, input logic go,
                      input logic ev, input string tag);
    exp_t  e;
    string t;
    bus.Result = res;
    bus.Start  = st;
    Reset      = rs;
    e.score = sc; e.lives = lv; e.playing = pl; e.win = wn; e.lose = go; e.evt = ev;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Clock);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (bus.Score === e.score) else begin
      bad++; $error("FAIL %s Score: got %0d want %0d", t, bus.Score, e.score);
    end
    total++;
    assert (bus.Lives === e.lives) else begin
      bad++; $error("FAIL %s Lives: got %0d want %0d", t, bus.Lives, e.lives);
    end
    total++;
    assert (bus.Playing === e.playing) else begin
      bad++; $error("FAIL %s Playing: got %b want %b", t, bus.Playing, e.playing);
    end
    total++;
    assert (bus.Win === e.win) else begin
      bad++; $error("FAIL %s Win: got %b want %b", t, bus.Win, e.win);
    end
    total++;
    assert (bus.Game_over === e.lose) else begin
      bad++; $error("FAIL %s Game_over: got %b want %b", t, bus.Game_over, e.lose);
    end
    total++;
    assert (bus.Event === e.evt) else begin
      bad++; $error("FAIL %s Event: got %b want %b", t, bus.Event, e.evt);
    end
  endtask

  initial begin
    bus.Result = 2'b00;
    bus.Start  = 1'b0;
    Reset      = 1'b1;
    @(posedge Clock);
    #1;

    //   res    st  rs  score lives pl wn go ev  tag
    step(2'b00, 0, 1, 8'd0, 3'd0, 0, 0, 0, 0, "reset0");
    step(2'b00, 1, 1, 8'd0, 3'd0, 0, 0, 0, 0, "reset_over_start");

    // Start, then a correct verdict held five cycles counts once.
    step(2'b00, 1, 0, 8'd0, 3'd3, 1, 0, 0, 0, "start");
    step(2'b01, 0, 0, 8'd1, 3'd3, 1, 0, 0, 1, "held01_first");
    for (int i = 0; i < 4; i++)
      step(2'b01, 0, 0, 8'd1, 3'd3, 1, 0, 0, 0, "held01_rest");
    step(2'b00, 0, 0, 8'd1, 3'd3, 1, 0, 0, 0, "release");

    // Fresh round: ten separated correct verdicts reach WIN; Start ignored in PLAY.
    step(2'b00, 0, 1, 8'd0, 3'd0, 0, 0, 0, 0, "midround_reset");
    step(2'b00, 1, 0, 8'd0, 3'd3, 1, 0, 0, 0, "start2");
    for (int i = 1; i <= 10; i++) begin
      step(2'b01, 0, 0, 8'(i), 3'd3, (i < 10), (i == 10), 0, 1, "win_verdict");
      step(2'b00, (i < 10), 0, 8'(i), 3'd3, (i < 10), (i == 10), 0, 0, "win_gap");
    end
    step(2'b10, 0, 0, 8'd10, 3'd3, 0, 1, 0, 0, "win_ignore10");
    step(2'b01, 0, 0, 8'd10, 3'd3, 0, 1, 0, 0, "win_ignore01");

    // Restart from WIN with a coincident flip 01->10: reload wins, no event.
    step(2'b10, 1, 0, 8'd0, 3'd3, 1, 0, 0, 0, "win_restart");
    step(2'b00, 0, 0, 8'd0, 3'd3, 1, 0, 0, 0, "gap");

    // 10,01,10,10 drains lives to LOSE; flips count as new verdicts.
    step(2'b10, 0, 0, 8'd0, 3'd2, 1, 0, 0, 1, "lose_w1");
    step(2'b01, 0, 0, 8'd1, 3'd2, 1, 0, 0, 1, "lose_c1");
    step(2'b10, 0, 0, 8'd1, 3'd1, 1, 0, 0, 1, "lose_w2");
    step(2'b10, 0, 0, 8'd1, 3'd1, 1, 0, 0, 0, "lose_held");
    step(2'b00, 0, 0, 8'd1, 3'd1, 1, 0, 0, 0, "lose_gap");
    step(2'b10, 0, 0, 8'd1, 3'd0, 0, 0, 1, 1, "lose_w3");
    step(2'b01, 0, 0, 8'd1, 3'd0, 0, 0, 1, 0, "lose_ignore01");
    step(2'b00, 0, 0, 8'd1, 3'd0, 0, 0, 1, 0, "lose_gap2");
    step(2'b10, 0, 0, 8'd1, 3'd0, 0, 0, 1, 0, "lose_ignore10");

    // Restart from LOSE with Result changing to 01: reload, no event, no count.
    step(2'b01, 1, 0, 8'd0, 3'd3, 1, 0, 0, 0, "lose_restart");
    step(2'b01, 0, 0, 8'd0, 3'd3, 1, 0, 0, 0, "discarded_held");

    // Build Score=4, Lives=2, then reset mid-round.
    for (int i = 1; i <= 4; i++) begin
      step(2'b00, 0, 0, 8'(i - 1), 3'd3, 1, 0, 0, 0, "build_gap");
      step(2'b01, 0, 0, 8'(i), 3'd3, 1, 0, 0, 1, "build_c");
    end
    step(2'b10, 0, 0, 8'd4, 3'd2, 1, 0, 0, 1, "build_w");
    step(2'b01, 0, 1, 8'd0, 3'd0, 0, 0, 0, 0, "reset_over_verdict");
    step(2'b01, 0, 0, 8'd0, 3'd0, 0, 0, 0, 0, "idle_held01");
    step(2'b10, 0, 0, 8'd0, 3'd0, 0, 0, 0, 0, "idle_10");
    step(2'b00, 0, 0, 8'd0, 3'd0, 0, 0, 0, 0, "idle_00");
    step(2'b01, 0, 0, 8'd0, 3'd0, 0, 0, 0, 0, "idle_01");

    // Start with a new verdict in IDLE: verdict discarded.
    step(2'b10, 1, 0, 8'd0, 3'd3, 1, 0, 0, 0, "idle_start_verdict");
    step(2'b01, 0, 0, 8'd1, 3'd3, 1, 0, 0, 1, "after_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter TARGET_SCORE, default 10: correct-guess count that wins a round; legal range 1..255.
REQ-002 Parameter START_LIVES, default 3: lives loaded at round start; legal range 1..7.
REQ-003 The design SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port Clock  input  1: rising-edge system clock.
REQ-005 Port Reset  input  1: synchronous, active-high reset.
REQ-006 Port Result  input  2: verdict from the decision stage; 01 = correct, 10 = wrong, 00/11 = no verdict; may be held for many cycles.
REQ-007 Port Start  input  1: request to begin a round; level-sampled each cycle.
REQ-008 Port Score  output  8: correct guesses in the current round.
REQ-009 Port Lives  output  3: remaining lives.
REQ-010 Port Playing  output  1: high while in state PLAY.
REQ-011 Port Win  output  1: high while in state WIN.
REQ-012 Port Game_over  output  1: high while in state LOSE.
REQ-013 Port Event  output  1: one-cycle pulse when a verdict is counted.

Function
REQ-014 All outputs SHALL be registered; every state change and output update SHALL take effect on the rising Clock edge after the causing input is sampled (latency 1 cycle).
REQ-015 Prev_result (2 bits) SHALL load Result on every cycle, in all states.
REQ-016 New verdict: Result in {01,10} and Result != Prev_result. A held verdict SHALL count once only.
REQ-017 A change 01->10 or 10->01 SHALL count as a new verdict.
REQ-018 FSM states SHALL be IDLE, PLAY, WIN and LOSE.
REQ-019 IDLE: Start=1 -> PLAY, Score=0, Lives=START_LIVES; otherwise remain in IDLE.
REQ-020 PLAY, new verdict 01: Score+1, Event=1; if Score+1 == TARGET_SCORE -> WIN.
REQ-021 PLAY, new verdict 10: Lives-1, Event=1; if Lives-1 == 0 -> LOSE.
REQ-022 PLAY with no new verdict: hold Score and Lives. Start SHALL be ignored in PLAY.
REQ-023 WIN/LOSE: Score and Lives held frozen; Start=1 -> PLAY with the same reload as REQ-019.
REQ-024 New verdicts in IDLE, WIN or LOSE SHALL be ignored: Event=0, no counter change.
REQ-025 Start and a new verdict in the same cycle outside PLAY: the Start reload wins and the verdict is discarded.
REQ-026 Score never exceeds TARGET_SCORE; Lives never underflows.
REQ-027 Event SHALL be 0 on every cycle not covered by REQ-020/REQ-021.

Reset
REQ-028 Reset=1 at any clock edge, including mid-round, SHALL force IDLE, Score=0, Lives=0, Prev_result=00, Playing=0, Win=0, Game_over=0, Event=0.
REQ-029 Reset SHALL take priority over Start and Result.
REQ-030 A Result held through reset deassertion SHALL count as a new verdict only if it differs from 00, in PLAY.

Verification
REQ-031 Reset, then Start pulse -> Playing=1, Score=0, Lives=3 one cycle later; Result=01 held 5 cycles -> Score=1, Event high for exactly 1 cycle.
REQ-032 In PLAY, Result sequence 01,00,01,00,... for 10 verdicts -> Score steps 1..10; Win=1 and Playing=0 on the cycle after the 10th verdict.
REQ-033 In PLAY, Result alternating 10,01,10,10 -> Lives 2, Score 1, Lives 1, Lives 0; Game_over=1; further verdicts leave Score=1 and Lives=0.
REQ-034 In LOSE, Start=1 with Result changing to 01 in the same cycle -> PLAY, Score=0, Lives=3, Event=0.
REQ-035 Mid-round (Score=4, Lives=2) assert Reset 1 cycle -> all outputs 0, state IDLE; verdicts before the next Start cause no Event.
